player_move_scheduler: RTL and testbench

//   Sequences player-position updates. Converts held direction buttons into

---
 rtl/player_move_scheduler_if.sv | 22 ++
 rtl/player_move_scheduler.sv | 140 ++++++++++++++
 tb/tb_player_move_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/player_move_scheduler_if.sv
// Step command channel between the move scheduler and the position datapath.
// Master drives a single-axis step; slave accepts it with step_ready.
interface player_move_scheduler_if;
   logic step_valid;
   logic step_axis;
   logic step_dec;
   logic step_ready;

   modport master (
      output step_valid,
      output step_axis,
      output step_dec,
      input  step_ready
   );

   modport slave (
      input  step_valid,
      input  step_axis,
      input  step_dec,
      output step_ready
   );
endinterface

// File: rtl/player_move_scheduler.sv
// Turns held direction buttons into rate-limited single-step commands,
// with opposing-button cancel, field bound drop and diagonal axis alternation.
module player_move_scheduler #(
   parameter int unsigned TICK_DIV   = 1666667,
   parameter int unsigned X_MAX      = 79,
   parameter int unsigned Y_MAX      = 59,
   parameter logic [3:0]  PLAY_STATE = 4'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic [6:0] pos_x,
   input  logic [6:0] pos_y,
   player_move_scheduler_if.master step,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE1 = 2'd1,
      ISSUE2 = 2'd2
   } fsm_t;

   localparam logic [20:0] TICK_LAST = 21'(TICK_DIV - 1);
   localparam logic [6:0]  XM        = 7'(X_MAX);
   localparam logic [6:0]  YM        = 7'(Y_MAX);

   fsm_t        fsm_q, fsm_d;
   logic [20:0] cnt_q, cnt_d;
   logic        axis_q, axis_d;
   logic        dec_q, dec_d;
   logic        pend_q, pend_d;
   logic        pend_dec_q, pend_dec_d;
   logic        prio_q, prio_d;

   logic play, any_btn, tick, hs;
   logic y_req, x_req;

   assign play    = (state == PLAY_STATE);
   assign any_btn = up | down | left | right;
   assign tick    = play & (cnt_q == TICK_LAST);

   // Opposing buttons cancel; a move off the field is dropped at sample time.
   assign y_req = (up ^ down)
                & ~(up & (pos_y >= YM))
                & ~(down & (pos_y == 7'd0));
   assign x_req = (left ^ right)
                & ~(right & (pos_x >= XM))
                & ~(left & (pos_x == 7'd0));

   assign step.step_valid = (fsm_q != IDLE);
   assign step.step_axis  = axis_q;
   assign step.step_dec   = dec_q;
   assign busy            = (fsm_q != IDLE);
   assign overrun         = tick & (fsm_q != IDLE);
   assign hs              = step.step_valid & step.step_ready;

   always_comb begin
      if (!play || !any_btn || tick) cnt_d = '0;
      else                           cnt_d = cnt_q + 21'd1;
   end

   always_comb begin
      fsm_d      = fsm_q;
      axis_d     = axis_q;
      dec_d      = dec_q;
      pend_d     = pend_q;
      pend_dec_d = pend_dec_q;
      prio_d     = prio_q;
      if (!play) begin
         fsm_d  = IDLE;
         pend_d = 1'b0;
      end else begin
         unique case (fsm_q)
            IDLE: begin
               if (tick && (y_req || x_req)) begin
                  fsm_d  = ISSUE1;
                  pend_d = y_req & x_req;
                  if (y_req && x_req) begin
                     axis_d     = prio_q;
                     dec_d      = prio_q ? down : left;
                     pend_dec_d = prio_q ? left : down;
                  end else if (y_req) begin
                     axis_d = 1'b1;
                     dec_d  = down;
                  end else begin
                     axis_d = 1'b0;
                     dec_d  = left;
                  end
               end
            end
            ISSUE1: begin
               if (hs) begin
                  if (pend_q) begin
                     fsm_d  = ISSUE2;
                     axis_d = ~axis_q;
                     dec_d  = pend_dec_q;
                  end else begin
                     fsm_d = IDLE;
                  end
               end
            end
            ISSUE2: begin
               if (hs) begin
                  fsm_d  = IDLE;
                  pend_d = 1'b0;
                  prio_d = ~prio_q;
               end
            end
            default: fsm_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q      <= IDLE;
         cnt_q      <= '0;
         axis_q     <= 1'b0;
         dec_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_dec_q <= 1'b0;
         prio_q     <= 1'b1;
      end else begin
         fsm_q      <= fsm_d;
         cnt_q      <= cnt_d;
         axis_q     <= axis_d;
         dec_q      <= dec_d;
         pend_q     <= pend_d;
         pend_dec_q <= pend_dec_d;
         prio_q     <= prio_d;
      end
   end

endmodule

// File: tb/tb_player_move_scheduler.sv
// Randomized bench for player_move_scheduler with a queue-based move model
// and a scoreboard that checks every accepted step and per-cycle status.
module tb_player_move_scheduler;
   localparam int TD = 4;

   logic       clk = 0;
   logic       rst;
   logic [3:0] state;
   logic       up, down, left, right;
   logic [6:0] pos_x, pos_y;
   logic       busy, overrun;

   player_move_scheduler_if sif();

   player_move_scheduler #(
      .TICK_DIV(TD), .X_MAX(79), .Y_MAX(59), .PLAY_STATE(4'd2)
   ) dut (
      .clk(clk), .rst(rst), .state(state),
      .up(up), .down(down), .left(left), .right(right),
      .pos_x(pos_x), .pos_y(pos_y),
      .step(sif.master),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [7:0] got, logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a list of moves owed to the datapath per tick.
   logic [1:0] m_mv[$];
   logic [1:0] exp_q[$];
   int         m_cnt = 0;
   bit         m_prio = 1;
   bit         m_pair = 0;
   bit         m_valid_pre = 0;
   bit         m_ovr = 0;
   logic [1:0] m_front = 0;

   function automatic void plan();
      bit yr, xr;
      yr = up ^ down;
      xr = left ^ right;
      if (up && pos_y >= 59) yr = 0;
      if (down && pos_y == 0) yr = 0;
      if (right && pos_x >= 79) xr = 0;
      if (left && pos_x == 0) xr = 0;
      m_pair = yr && xr;
      if (yr && xr) begin
         if (m_prio) begin
            m_mv.push_back({1'b1, down});
            m_mv.push_back({1'b0, left});
         end else begin
            m_mv.push_back({1'b0, left});
            m_mv.push_back({1'b1, down});
         end
      end else if (yr) begin
         m_mv.push_back({1'b1, down});
      end else if (xr) begin
         m_mv.push_back({1'b0, left});
      end
   endfunction

   always @(posedge clk) begin
      bit bsy, tk;
      logic [1:0] mv;
      m_valid_pre = 0;
      m_ovr = 0;
      if (rst) begin
         m_mv.delete();
         m_cnt = 0;
         m_prio = 1;
         m_pair = 0;
      end else begin
         m_valid_pre = m_mv.size() > 0;
         if (m_valid_pre) m_front = m_mv[0];
         if (state != 4'd2) begin
            m_mv.delete();
            m_cnt = 0;
         end else begin
            bsy = m_valid_pre;
            tk = (m_cnt == TD - 1);
            if (bsy && sif.step_ready) begin
               mv = m_mv.pop_front();
               exp_q.push_back(mv);
               if (m_mv.size() == 0 && m_pair) m_prio = !m_prio;
            end
            if (tk) begin
               if (bsy) m_ovr = 1;
               else plan();
            end
            if (!(up | down | left | right) || tk) m_cnt = 0;
            else m_cnt = m_cnt + 1;
         end
      end
   end

   // Monitor: captures pre-edge outputs, compares once the model has stepped.
   always @(posedge clk) begin
      logic v, r, a, d, b, o, rs;
      logic [3:0] st;
      v = sif.step_valid; r = sif.step_ready;
      a = sif.step_axis;  d = sif.step_dec;
      b = busy; o = overrun; rs = rst; st = state;
      #1;
      check("valid", {7'd0, v}, {7'd0, m_valid_pre});
      check("busy", {7'd0, b}, {7'd0, m_valid_pre});
      check("overrun", {7'd0, o}, {7'd0, m_ovr});
      if (v && m_valid_pre) check("fields", {6'd0, a, d}, {6'd0, m_front});
      if (v && r && !rs && st == 4'd2) begin
         if (exp_q.size() == 0) check("step_unexpected", 8'd1, 8'd0);
         else check("step", {6'd0, a, d}, {6'd0, exp_q.pop_front()});
      end
   end

   task automatic btn(bit u, bit dn, bit l, bit rt);
      up = u; down = dn; left = l; right = rt;
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_outs(string tag);
      check({tag, "_valid"}, {7'd0, sif.step_valid}, 8'd0);
      check({tag, "_axis"}, {7'd0, sif.step_axis}, 8'd0);
      check({tag, "_dec"}, {7'd0, sif.step_dec}, 8'd0);
      check({tag, "_busy"}, {7'd0, busy}, 8'd0);
      check({tag, "_ovr"}, {7'd0, overrun}, 8'd0);
   endtask

   initial begin
      rst = 1; state = 4'd2; btn(0, 0, 0, 0);
      pos_x = 7'd10; pos_y = 7'd10;
      sif.step_ready = 1;
      #1;
      chk_reset_outs("reset");
      cyc(3);
      rst = 0;

      btn(1, 0, 0, 0); cyc(20);
      btn(1, 0, 0, 1); cyc(24);
      btn(0, 0, 0, 0); cyc(3);

      pos_y = 7'd59; btn(1, 0, 0, 0); cyc(12);
      pos_y = 7'd10; pos_x = 7'd0; btn(0, 0, 1, 0); cyc(12);
      pos_x = 7'd10; btn(1, 1, 0, 0); cyc(12);
      btn(0, 0, 1, 1); cyc(12);
      btn(0, 0, 0, 0); cyc(2);

      sif.step_ready = 0; btn(0, 1, 0, 0);
      for (int i = 0; i < 20 && !sif.step_valid; i++) cyc(1);
      if (!sif.step_valid) check("wait_valid", 8'd0, 8'd1);
      cyc(10);
      sif.step_ready = 1; cyc(3);

      sif.step_ready = 0; btn(0, 0, 1, 0);
      for (int i = 0; i < 20 && !sif.step_valid; i++) cyc(1);
      if (!sif.step_valid) check("wait_valid2", 8'd0, 8'd1);
      state = 4'd0; cyc(3);
      state = 4'd2; sif.step_ready = 1; cyc(12);

      sif.step_ready = 0; btn(0, 1, 0, 1);
      for (int i = 0; i < 20 && !sif.step_valid; i++) cyc(1);
      if (!sif.step_valid) check("wait_valid3", 8'd0, 8'd1);
      sif.step_ready = 1; cyc(1);
      sif.step_ready = 0; cyc(2);
      rst = 1;
      #1;
      chk_reset_outs("midrst");
      cyc(1);
      rst = 0; sif.step_ready = 1; cyc(12);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(7) == 0) btn($urandom_range(1), $urandom_range(1),
                                         $urandom_range(1), $urandom_range(1));
         sif.step_ready = ($urandom_range(9) < 7);
         if ($urandom_range(15) == 0) begin
            case ($urandom_range(3))
               0: pos_x = 7'd0;
               1: pos_x = 7'd79;
               2: pos_x = 7'd78;
               default: pos_x = 7'($urandom_range(127));
            endcase
         end
         if ($urandom_range(15) == 0) begin
            case ($urandom_range(3))
               0: pos_y = 7'd0;
               1: pos_y = 7'd59;
               2: pos_y = 7'd1;
               default: pos_y = 7'($urandom_range(127));
            endcase
         end
         if ($urandom_range(63) == 0) state = (state == 4'd2) ? 4'($urandom_range(15)) : 4'd2;
         rst = ($urandom_range(499) == 0);
      end
      rst = 0; state = 4'd2; btn(0, 0, 0, 0); sif.step_ready = 1;
      cyc(8);
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
